// File: rtl/uart_pkg.sv
// Shared types for the UART receive-to-memory path.
// Receiver/packer state encodings, data width and lane helpers.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        P_IDLE,
        P_COLLECT,
        P_WRITE
    } pk_state_e;

    typedef logic [1:0] lane_t;

    function automatic logic [3:0] lane_mask(lane_t l);
        return 4'b0001 << l;
    endfunction

endpackage

// File: rtl/uart_rx_dma_if.sv
// Avalon-MM write-only master bundle used by the UART receive path.
// Master drives the request; slave drives waitrequest.
interface uart_rx_dma_if;
    logic        write;
    logic [15:0] address;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;

    modport master (
        output write, address, writedata, byteenable,
        input  waitrequest
    );

    modport slave (
        input  write, address, writedata, byteenable,
        output waitrequest
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 bit-level receiver: 2-flop synchroniser plus an oversampled FSM.
// Emits a one-clk byte_valid with the byte and the sampled stop bit.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       uart_rx,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       stop_ok
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    logic [1:0]    sync_q;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          stop_q, stop_d;
    logic          rx_s;

    assign rx_s       = sync_q[1];
    assign byte_valid = valid_q;
    assign rx_byte    = shift_q;
    assign stop_ok    = stop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            state_q <= R_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], uart_rx};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            stop_q  <= stop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        stop_d  = stop_q;
        if (tick) begin
            unique case (state_q)
                R_IDLE: begin
                    if (!rx_s) begin
                        state_d = R_START;
                        cnt_d   = '0;
                    end
                end
                R_START: begin
                    // Mid-start sample rejects short glitches.
                    if (cnt_q == HALF) begin
                        if (rx_s) begin
                            state_d = R_IDLE;
                        end else begin
                            state_d = R_DATA;
                            cnt_d   = '0;
                            bit_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                R_DATA: begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        shift_d = {rx_s, shift_q[7:1]};
                        if (bit_q == 3'(DATA_BITS - 1)) begin
                            state_d = R_STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                R_STOP: begin
                    if (cnt_q == LAST) begin
                        valid_d = 1'b1;
                        stop_d  = rx_s;
                        cnt_d   = '0;
                        state_d = R_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_dma.sv
// UART receive path packing bytes into 32-bit Avalon-MM writes.
// Optional framing-error detection with UART_RX_FERR_EN.
module uart_rx_dma
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        uart_rx,
    input  logic        control_recv_start,
    input  logic [15:0] control_recv_start_addr,
    input  logic [15:0] control_recv_stop_addr,
    output logic        control_recv_work,
    output logic        control_recv_overflow,
`ifdef UART_RX_FERR_EN
    output logic        control_recv_ferr,
`endif
    uart_rx_dma_if.master avm_m1
);

    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       stop_ok;
    logic       byte_ok;

    uart_receiver #(.OVERSAMPLE(OVERSAMPLE)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .uart_rx    (uart_rx),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .stop_ok    (stop_ok)
    );

`ifdef UART_RX_FERR_EN
    logic ferr_q, ferr_d;
    assign byte_ok           = byte_valid & stop_ok;
    assign control_recv_ferr = ferr_q;
`else
    logic unused_stop_ok;
    assign unused_stop_ok = stop_ok;
    assign byte_ok        = byte_valid;
`endif

    pk_state_e   st_q, st_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] stp_q, stp_d;
    logic [31:0] word_q, word_d;
    logic [3:0]  be_q, be_d;
    logic        pend_v_q, pend_v_d;
    logic [7:0]  pend_q, pend_d;
    logic        ovf_q, ovf_d;
    logic        work_q;
    lane_t       lane;
    logic        in_v;
    logic [7:0]  in_b;
    logic        wr;

    assign lane = addr_q[1:0];
    assign wr   = (st_q == P_WRITE);

    assign avm_m1.write      = wr;
    assign avm_m1.address    = wr ? {addr_q[15:2], 2'b00} : 16'h0;
    assign avm_m1.writedata  = wr ? word_q : 32'h0;
    assign avm_m1.byteenable = wr ? be_q : 4'h0;

    assign control_recv_work     = work_q;
    assign control_recv_overflow = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q     <= P_IDLE;
            addr_q   <= '0;
            stp_q    <= '0;
            word_q   <= '0;
            be_q     <= '0;
            pend_v_q <= 1'b0;
            pend_q   <= '0;
            ovf_q    <= 1'b0;
            work_q   <= 1'b0;
        end else begin
            st_q     <= st_d;
            addr_q   <= addr_d;
            stp_q    <= stp_d;
            word_q   <= word_d;
            be_q     <= be_d;
            pend_v_q <= pend_v_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            work_q   <= (st_d != P_IDLE);
        end
    end

`ifdef UART_RX_FERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ferr_q <= 1'b0;
        else     ferr_q <= ferr_d;
    end

    always_comb begin
        ferr_d = ferr_q;
        if (st_q == P_IDLE) begin
            if (control_recv_start) ferr_d = 1'b0;
        end else if (byte_valid && !stop_ok) begin
            ferr_d = 1'b1;
        end
    end
`endif

    // The buffered byte is older than any byte arriving now.
    assign in_v = pend_v_q | byte_ok;
    assign in_b = pend_v_q ? pend_q : rx_byte;

    always_comb begin
        st_d     = st_q;
        addr_d   = addr_q;
        stp_d    = stp_q;
        word_d   = word_q;
        be_d     = be_q;
        pend_v_d = pend_v_q;
        pend_d   = pend_q;
        ovf_d    = ovf_q;
        unique case (st_q)
            P_IDLE: begin
                if (control_recv_start) begin
                    addr_d   = control_recv_start_addr;
                    stp_d    = control_recv_stop_addr;
                    word_d   = '0;
                    be_d     = '0;
                    ovf_d    = 1'b0;
                    pend_v_d = 1'b0;
                    st_d     = P_COLLECT;
                end
            end
            P_COLLECT: begin
                if (pend_v_q) begin
                    pend_v_d = byte_ok;
                    if (byte_ok) pend_d = rx_byte;
                end
                if (in_v) begin
                    word_d[{lane, 3'b000} +: 8] = in_b;
                    be_d = be_q | lane_mask(lane);
                    if (addr_q == stp_q || lane == 2'd3) begin
                        st_d = P_WRITE;
                    end else begin
                        addr_d = addr_q + 16'd1;
                    end
                end
            end
            P_WRITE: begin
                if (byte_ok) begin
                    if (pend_v_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        pend_v_d = 1'b1;
                        pend_d   = rx_byte;
                    end
                end
                if (!avm_m1.waitrequest) begin
                    if (addr_q == stp_q) begin
                        st_d = P_IDLE;
                    end else begin
                        addr_d = addr_q + 16'd1;
                        word_d = '0;
                        be_d   = '0;
                        st_d   = P_COLLECT;
                    end
                end
            end
            default: st_d = P_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_dma.sv
// Scoreboard bench for uart_rx_dma: serial bytes in, expected writes queued.
// Build with +define+UART_RX_FERR_EN to cover framing-error handling.
module tb_uart_rx_dma;

    localparam int OS = 16;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        uart_rx = 1'b1;
    logic        start = 1'b0;
    logic [15:0] sa = '0;
    logic [15:0] sp = '0;
    logic        work;
    logic        ovf;
`ifdef UART_RX_FERR_EN
    logic        ferr;
`endif

    uart_rx_dma_if avm ();

    uart_rx_dma #(.OVERSAMPLE(OS)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .tick                    (tick),
        .uart_rx                 (uart_rx),
        .control_recv_start      (start),
        .control_recv_start_addr (sa),
        .control_recv_stop_addr  (sp),
        .control_recv_work       (work),
        .control_recv_overflow   (ovf),
`ifdef UART_RX_FERR_EN
        .control_recv_ferr       (ferr),
`endif
        .avm_m1                  (avm.master)
    );

    always #5 clk = ~clk;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  tdiv = 0;
    logic prev_stall = 1'b0;
    wr_t  prev;

    // Observe the values the next posedge will see, then advance one clk.
    task automatic step();
        wr_t e;
        wr_t cur;
        #1;
        cur = {avm.address, avm.writedata, avm.byteenable};
        if (prev_stall && avm.write) begin
            checks++;
            if (cur !== prev) begin
                errors++;
                $display("FAIL hold_stable: got %h, required %h", cur, prev);
            end
        end
        if (avm.write && avm.waitrequest === 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got a=%h d=%h be=%b, required none",
                         cur.a, cur.d, cur.be);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e) begin
                    errors++;
                    $display("FAIL write: got a=%h d=%h be=%b, required a=%h d=%h be=%b",
                             cur.a, cur.d, cur.be, e.a, e.d, e.be);
                end
            end
        end
        prev_stall = avm.write && avm.waitrequest && !rst;
        prev = cur;
        @(negedge clk);
        tdiv = (tdiv + 1) % 4;
        tick = (tdiv == 0);
    endtask

    task automatic send_bit(input logic v);
        int k;
        k = 0;
        uart_rx = v;
        while (k < OS) begin
            step();
            if (tick) k++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stopbit = 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stopbit);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic open_window(input logic [15:0] a, input logic [15:0] b);
        sa = a;
        sp = b;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (work !== 1'b1) begin
            errors++;
            $display("FAIL work_rise: got %b, required 1", work);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (work && n < 20000) begin
            step();
            n++;
        end
        checks++;
        if (work !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: work got %b, required 0", name, work);
        end
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: got %0d pending writes, required 0",
                     name, exp_q.size());
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({avm.write, avm.address, avm.writedata, avm.byteenable, work, ovf} !== '0) begin
            errors++;
            $display("FAIL %s: got w=%b a=%h d=%h be=%b work=%b ovf=%b, required all 0",
                     name, avm.write, avm.address, avm.writedata, avm.byteenable, work, ovf);
        end
`ifdef UART_RX_FERR_EN
        checks++;
        if (ferr !== 1'b0) begin
            errors++;
            $display("FAIL %s_ferr: got %b, required 0", name, ferr);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) step();
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (4) step();
        check_outputs_zero("after_reset");
    endtask

    task automatic test_basic();
        open_window(16'h0010, 16'h0013);
        exp_q.push_back({16'h0010, 32'h44332211, 4'hF});
        send_byte(8'h11);
        sa = 16'h0100;
        sp = 16'h0200;
        start = 1'b1;
        step();
        start = 1'b0;
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        wait_idle("basic");
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_ovf: got %b, required 0", ovf);
        end
    endtask

    task automatic test_single();
        open_window(16'h0005, 16'h0005);
        exp_q.push_back({16'h0004, 32'h0000A500, 4'b0010});
        send_byte(8'hA5);
        wait_idle("single");
    endtask

    task automatic test_wrap();
        open_window(16'hFFFE, 16'h0001);
        exp_q.push_back({16'hFFFC, 32'hBBAA0000, 4'b1100});
        exp_q.push_back({16'h0000, 32'h0000DDCC, 4'b0011});
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        wait_idle("wrap");
    endtask

    task automatic test_overflow();
        avm.waitrequest = 1'b1;
        open_window(16'h0020, 16'h0027);
        exp_q.push_back({16'h0020, 32'h04030201, 4'hF});
        exp_q.push_back({16'h0024, 32'h0A090805, 4'hF});
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        checks++;
        if (avm.write !== 1'b1) begin
            errors++;
            $display("FAIL ovf_stall_write: got %b, required 1", avm.write);
        end
        send_byte(8'h05);
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_buffered: got %b, required 0", ovf);
        end
        send_byte(8'h06);
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got %b, required 1", ovf);
        end
        send_byte(8'h07);
        avm.waitrequest = 1'b0;
        send_byte(8'h08);
        send_byte(8'h09);
        send_byte(8'h0A);
        wait_idle("overflow");
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b, required 1", ovf);
        end
    endtask

    task automatic test_glitch();
        int k;
        open_window(16'h0040, 16'h0040);
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b, required 0", ovf);
        end
        k = 0;
        uart_rx = 1'b0;
        while (k < OS / 4) begin
            step();
            if (tick) k++;
        end
        idle_bits(3);
        checks++;
        if (work !== 1'b1 || avm.write !== 1'b0) begin
            errors++;
            $display("FAIL glitch: got work=%b write=%b, required work=1 write=0",
                     work, avm.write);
        end
`ifdef UART_RX_FERR_EN
        send_byte(8'h77, 1'b0);
        idle_bits(2);
        checks++;
        if (ferr !== 1'b1 || work !== 1'b1) begin
            errors++;
            $display("FAIL ferr_set: got ferr=%b work=%b, required 1 1", ferr, work);
        end
`endif
        exp_q.push_back({16'h0040, 32'h0000005A, 4'b0001});
        send_byte(8'h5A);
        wait_idle("glitch");
`ifdef UART_RX_FERR_EN
        checks++;
        if (ferr !== 1'b1) begin
            errors++;
            $display("FAIL ferr_sticky: got %b, required 1", ferr);
        end
`endif
    endtask

    task automatic test_reset_mid();
        open_window(16'h0080, 16'h0083);
        send_byte(8'h01);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        #1;
        check_outputs_zero("rst_mid_byte");
        uart_rx = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();

        avm.waitrequest = 1'b1;
        open_window(16'h0030, 16'h0033);
        send_byte(8'hE1);
        send_byte(8'hE2);
        send_byte(8'hE3);
        send_byte(8'hE4);
        repeat (3) step();
        checks++;
        if (avm.write !== 1'b1) begin
            errors++;
            $display("FAIL rst_write_pending: got %b, required 1", avm.write);
        end
        rst = 1'b1;
        #1;
        check_outputs_zero("rst_mid_write");
        avm.waitrequest = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();

        open_window(16'h0010, 16'h0013);
        exp_q.push_back({16'h0010, 32'h88776655, 4'hF});
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        send_byte(8'h88);
        wait_idle("post_reset");
    endtask

    initial begin
        avm.waitrequest = 1'b0;
        test_reset();
        test_basic();
        test_single();
        test_wrap();
        test_overflow();
        test_glitch();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
